alu_mc: RTL

//  Parametrised multi-cycle ALU. Successor to the combinational 8-op ALU (same sel encoding).

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_mc_if.sv | 33 +++
 rtl/alu_shift_unit.sv | 63 ++++++
 rtl/alu_mc.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : op codes, FSM state encodings and flag indices for alu_mc
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] OP_SADD = 3'd0;
  localparam logic [2:0] OP_UADD = 3'd1;
  localparam logic [2:0] OP_SSUB = 3'd2;
  localparam logic [2:0] OP_USUB = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_SRA  = 3'd6;
  localparam logic [2:0] OP_SRL  = 3'd7;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE_ENC,
    S_SHIFT = ST_SHIFT_ENC,
    S_DONE  = ST_DONE_ENC
  } state_t;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int NFLAGS     = 3;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SRA) || (op == OP_SRL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mc_if.sv
// ============================================================================
// alu_mc_if : issue-side and result-side handshake bundle for alu_mc
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_carry;
  logic             out_ovf;

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_carry, out_ovf
  );

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_carry, out_ovf
  );
endinterface

`default_nettype wire

// File: rtl/alu_shift_unit.sv
// ============================================================================
// alu_shift_unit : one-bit-per-cycle shifter, or single-cycle barrel shifter
//                  when ALU_BARREL_SHIFT_EN is defined
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_start,
  input  wire logic             i_sra,
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [SHW-1:0]   i_shamt,
  output logic                  o_done,
  output logic [WIDTH-1:0]      o_result
);

`ifndef ALU_BARREL_SHIFT_EN
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic             r_sra;
  logic [WIDTH-1:0] w_step;

  assign w_step = r_sra ? {r_work[WIDTH-1], r_work[WIDTH-1:1]}
                        : {1'b0, r_work[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_sra  <= 1'b0;
    end else if (i_start) begin
      r_work <= i_a;
      r_cnt  <= i_shamt;
      r_sra  <= i_sra;
    end else if (r_cnt != '0) begin
      r_work <= w_step;
      r_cnt  <= r_cnt - SHW'(1);
    end
  end

  // The step taken while the counter reads 1 is the final one.
  assign o_done   = (r_cnt == SHW'(1));
  assign o_result = w_step;
`else
  logic signed [WIDTH-1:0] w_sra;
  logic                    w_unused;

  assign w_sra    = $signed(i_a) >>> i_shamt;
  assign o_result = i_sra ? w_sra : (i_a >> i_shamt);
  assign o_done   = i_start;
  assign w_unused = &{1'b0, clk, rst};
`endif

endmodule

`default_nettype wire

// File: rtl/alu_mc.sv
// ============================================================================
// alu_mc : multi-cycle 8-op ALU with valid/ready handshakes and flags;
//          ALU_BARREL_SHIFT_EN selects single-cycle shifts
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input wire logic clk,
  input wire logic rst,
  alu_mc_if.slave  bus
);

  state_t             r_state;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [NFLAGS-1:0]  r_flags;

  logic               w_in_ready;
  logic               w_accept;
  logic [SHW-1:0]     w_shamt;
  logic               w_go_shift;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_res;
  logic [NFLAGS-1:0]  w_flags;
  logic               w_sh_done;
  logic [WIDTH-1:0]   w_sh_result;

  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_shamt    = bus.b[SHW-1:0];

`ifdef ALU_BARREL_SHIFT_EN
  assign w_go_shift = 1'b0;
`else
  assign w_go_shift = is_shift_op(bus.sel) && (w_shamt != '0);
`endif

  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};

  always_comb begin
    w_res   = '0;
    w_flags = '0;
    case (bus.sel)
      OP_SADD: begin
        w_res             = w_sum[WIDTH-1:0];
        w_flags[FLAG_OVF] = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_UADD: begin
        w_res               = w_sum[WIDTH-1:0];
        w_flags[FLAG_CARRY] = w_sum[WIDTH];
      end
      OP_SSUB: begin
        w_res             = w_diff[WIDTH-1:0];
        w_flags[FLAG_OVF] = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_USUB: begin
        w_res               = w_diff[WIDTH-1:0];
        w_flags[FLAG_CARRY] = w_diff[WIDTH];
      end
      OP_AND:  w_res = bus.a & bus.b;
      OP_OR:   w_res = bus.a | bus.b;
`ifdef ALU_BARREL_SHIFT_EN
      default: w_res = w_sh_result;
`else
      // Iterative shifts reaching here have a zero shift amount.
      default: w_res = bus.a;
`endif
    endcase
    w_flags[FLAG_ZERO] = (w_res == '0);
  end

  alu_shift_unit #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept && w_go_shift),
    .i_sra    (bus.sel == OP_SRA),
    .i_a      (bus.a),
    .i_shamt  (w_shamt),
    .o_done   (w_sh_done),
    .o_result (w_sh_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_flags     <= '0;
    end else if (w_accept) begin
      if (w_go_shift) begin
        r_state     <= S_SHIFT;
        r_out_valid <= 1'b0;
      end else begin
        r_state     <= S_DONE;
        r_out_valid <= 1'b1;
        r_out_data  <= w_res;
        r_flags     <= w_flags;
      end
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (w_sh_done) begin
            r_state             <= S_DONE;
            r_out_valid         <= 1'b1;
            r_out_data          <= w_sh_result;
            r_flags             <= '0;
            r_flags[FLAG_ZERO]  <= (w_sh_result == '0);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_zero  = r_flags[FLAG_ZERO];
  assign bus.out_carry = r_flags[FLAG_CARRY];
  assign bus.out_ovf   = r_flags[FLAG_OVF];

endmodule

`default_nettype wire
